// File: rtl/ppu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency PPU, with in-order result routing by tag.
// Optional per-requester acceptance counters: define PPU_ARB_STATS_EN.
module ppu_arbiter #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [WORD-1:0]    req0_in1,
    input  logic [WORD-1:0]    req0_in2,
    input  logic [WORD-1:0]    req1_in1,
    input  logic [WORD-1:0]    req1_in2,
    input  logic [OP_SIZE-1:0] req0_op,
    input  logic [OP_SIZE-1:0] req1_op,
    output logic               res0_valid,
    output logic               res1_valid,
    output logic [WORD-1:0]    res0_data,
    output logic [WORD-1:0]    res1_data,
    output logic               ppu_valid_in,
    output logic [WORD-1:0]    ppu_in1,
    output logic [WORD-1:0]    ppu_in2,
    output logic [OP_SIZE-1:0] ppu_op,
    input  logic [WORD-1:0]    ppu_out,
    input  logic               ppu_valid_o,
`ifdef PPU_ARB_STATS_EN
    output logic [31:0]        cnt0,
    output logic [31:0]        cnt1,
`endif
    output logic               err
);

    logic               last_grant;
    logic               grant0, grant1, accept, sel;
    logic               issue_id;
    logic [LATENCY-1:0] tag_vld, tag_id;
    logic               head_vld, head_id;

    // last_grant==1 means requester 0 wins the next tie.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & ~grant0;
    end

    // Ready is held low while reset is asserted, even though it is combinational.
    assign req0_ready = rst_n & grant0;
    assign req1_ready = rst_n & grant1;
    assign accept     = req0_ready | req1_ready;
    assign sel        = req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            ppu_valid_in <= 1'b0;
            ppu_in1      <= '0;
            ppu_in2      <= '0;
            ppu_op       <= '0;
            issue_id     <= 1'b0;
        end else begin
            ppu_valid_in <= accept;
            if (accept) begin
                last_grant <= sel;
                issue_id   <= sel;
                ppu_in1    <= sel ? req1_in1 : req0_in1;
                ppu_in2    <= sel ? req1_in2 : req0_in2;
                ppu_op     <= sel ? req1_op  : req0_op;
            end
        end
    end

    // Tags enter one cycle after issue, so the head lines up with ppu_valid_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= ppu_valid_in;
            tag_id[0]  <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign head_vld = tag_vld[LATENCY-1];
    assign head_id  = tag_id[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_data  <= '0;
            res1_data  <= '0;
            err        <= 1'b0;
        end else begin
            res0_valid <= ppu_valid_o & head_vld & ~head_id;
            res1_valid <= ppu_valid_o & head_vld &  head_id;
            if (ppu_valid_o && head_vld && !head_id) res0_data <= ppu_out;
            if (ppu_valid_o && head_vld &&  head_id) res1_data <= ppu_out;
            if (ppu_valid_o != head_vld) err <= 1'b1;
        end
    end

`ifdef PPU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req0_ready) cnt0 <= cnt0 + 32'd1;
            if (req1_ready) cnt1 <= cnt1 + 32'd1;
        end
    end
`endif

endmodule
